// File: rtl/fifo_stream_reader.sv
// Drains a 1-cycle-latency FIFO into a framed valid/ready stream through a 2-entry skid buffer.
// Latency: 2 cycles from read to valid. Backpressure: reads stop once the buffer plus in-flight reach 2.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_fifo_empty,
    input  logic [DATA_WIDTH-1:0] i_fifo_dout,
    output logic                  o_fifo_rd_en,
    output logic                  o_m_valid,
    output logic [DATA_WIDTH-1:0] o_m_data,
    output logic                  o_m_last,
    input  logic                  i_m_ready,
    input  logic                  i_flush,
    output logic                  o_busy
);

    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BURST_LEN - 1);

    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic       pop;
    logic       cap;
    logic       rd_issue;
    logic [1:0] pending;

    assign o_m_valid    = (occ_q != 2'd0);
    assign o_m_data     = buf0_q;
    assign o_m_last     = o_m_valid & (cnt_q == LAST_BEAT);
    assign o_busy       = (occ_q != 2'd0) | inflight_q;
    // Reset gating lives only on the output so the flop inputs stay reset-free.
    assign o_fifo_rd_en = rd_issue & i_rst_n;

    always_comb begin
        pending  = occ_q + {1'b0, inflight_q};
        pop      = o_m_valid & i_m_ready;
        rd_issue = !i_fifo_empty & !i_flush & ((pending < 2'd2) | pop);
        cap      = inflight_q & !i_flush;

        occ_d      = occ_q;
        inflight_d = rd_issue;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        cnt_d      = cnt_q;

        if (i_flush) begin
            occ_d = 2'd0;
            cnt_d = '0;
        end else begin
            if (pop) begin
                cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + CNT_WIDTH'(1);
            end
            // Head is buf0; a pop shifts buf1 forward, a capture fills the first free slot.
            case ({cap, pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        buf0_d = i_fifo_dout;
                    end else begin
                        buf1_d = i_fifo_dout;
                    end
                    occ_d = occ_q + 2'd1;
                end
                2'b01: begin
                    buf0_d = buf1_q;
                    occ_d  = occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd2) begin
                        buf0_d = buf1_q;
                        buf1_d = i_fifo_dout;
                    end else begin
                        buf0_d = i_fifo_dout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            cnt_q      <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule
